rf_16b: RTL and testbench



---
 rtl/rf_16b.sv | 43 ++++
 tb/tb_rf_16b.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_16b.sv
// Eight-entry, 16-bit register file with two combinational read ports and one
// synchronous write port. All registers clear asynchronously when rst_n is low.
module rf_16b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  read_register0,
    input  logic [2:0]  read_register1,
    input  logic [2:0]  write_register,
    input  logic        RegWrite,
    input  logic [15:0] write_data,
    output logic [15:0] read_data0,
    output logic [15:0] read_data1
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (RegWrite) begin
            regs_d[write_register] = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads come straight off the array, so a write shows up only after its edge.
    assign read_data0 = regs_q[read_register0];
    assign read_data1 = regs_q[read_register1];

endmodule

// File: tb/tb_rf_16b.sv
// Self-checking bench for rf_16b: directed scenarios plus randomized traffic
// compared against an array model of the eight registers.
module tb_rf_16b;

    logic        clk;
    logic        rst_n;
    logic [2:0]  read_register0;
    logic [2:0]  read_register1;
    logic [2:0]  write_register;
    logic        RegWrite;
    logic [15:0] write_data;
    logic [15:0] read_data0;
    logic [15:0] read_data1;

    logic [15:0] model [8];
    int checksTotal;
    int checksPassed;

    rf_16b dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_register0 (read_register0),
        .read_register1 (read_register1),
        .write_register (write_register),
        .RegWrite       (RegWrite),
        .write_data     (write_data),
        .read_data0     (read_data0),
        .read_data1     (read_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle write pulse straddling a single rising edge; keeps the model in step.
    task automatic applyWrite(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        write_register = addr;
        write_data     = data;
        RegWrite       = 1'b1;
        @(negedge clk);
        RegWrite       = 1'b0;
        model[addr]    = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int a = 0; a < 8; a++) begin
            read_register0 = a[2:0];
            read_register1 = 3'(7 - a);
            #1;
            checksTotal++;
            if (read_data0 !== 16'h0000)
                $display("[TB] FAIL reset_rd0 addr=%0d got=%h exp=0000", a, read_data0);
            else checksPassed++;
            checksTotal++;
            if (read_data1 !== 16'h0000)
                $display("[TB] FAIL reset_rd1 addr=%0d got=%h exp=0000", 7 - a, read_data1);
            else checksPassed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_writes();
        applyWrite(3'd3, 16'hAAAA);
        applyWrite(3'd5, 16'h5555);
        applyWrite(3'd2, 16'hFFFF);
        applyWrite(3'd1, 16'hA5A5);
        for (int a = 0; a < 8; a++) begin
            logic [15:0] expA;
            case (a)
                3: expA = 16'hAAAA;
                5: expA = 16'h5555;
                2: expA = 16'hFFFF;
                1: expA = 16'hA5A5;
                default: expA = 16'h0000;
            endcase
            read_register0 = a[2:0];
            read_register1 = a[2:0];
            #1;
            checksTotal++;
            if (read_data0 !== expA)
                $display("[TB] FAIL basic_rd0 addr=%0d got=%h exp=%h", a, read_data0, expA);
            else checksPassed++;
            checksTotal++;
            if (read_data1 !== expA)
                $display("[TB] FAIL basic_rd1 addr=%0d got=%h exp=%h", a, read_data1, expA);
            else checksPassed++;
        end
    endtask

    task automatic test_write_enable();
        @(negedge clk);
        RegWrite       = 1'b0;
        write_register = 3'd4;
        write_data     = 16'h1234;
        read_register0 = 3'd4;
        repeat (4) @(negedge clk);
        checksTotal++;
        if (read_data0 !== 16'h0000)
            $display("[TB] FAIL we_gating got=%h exp=0000", read_data0);
        else checksPassed++;
    endtask

    task automatic test_same_cycle_read();
        @(negedge clk);
        read_register0 = 3'd6;
        write_register = 3'd6;
        write_data     = 16'hBEEF;
        RegWrite       = 1'b1;
        #1;
        checksTotal++;
        if (read_data0 !== 16'h0000)
            $display("[TB] FAIL same_cycle_before got=%h exp=0000", read_data0);
        else checksPassed++;
        @(posedge clk);
        #1;
        checksTotal++;
        if (read_data0 !== 16'hBEEF)
            $display("[TB] FAIL same_cycle_after got=%h exp=beef", read_data0);
        else checksPassed++;
        @(negedge clk);
        RegWrite = 1'b0;
        model[6] = 16'hBEEF;
    endtask

    task automatic test_back_to_back();
        // Consecutive edges: R7 twice, then R0, no idle cycle between.
        @(negedge clk);
        RegWrite       = 1'b1;
        write_register = 3'd7;
        write_data     = 16'h0F0F;
        @(negedge clk);
        write_data     = 16'hF0F0;
        @(negedge clk);
        write_register = 3'd0;
        write_data     = 16'h0042;
        @(negedge clk);
        RegWrite       = 1'b0;
        model[7] = 16'hF0F0;
        model[0] = 16'h0042;
        read_register0 = 3'd7;
        read_register1 = 3'd7;
        #1;
        checksTotal++;
        if (read_data0 !== 16'hF0F0)
            $display("[TB] FAIL dual_same_rd0 got=%h exp=f0f0", read_data0);
        else checksPassed++;
        checksTotal++;
        if (read_data1 !== 16'hF0F0)
            $display("[TB] FAIL dual_same_rd1 got=%h exp=f0f0", read_data1);
        else checksPassed++;
        read_register1 = 3'd0;
        #1;
        checksTotal++;
        if (read_data1 !== 16'h0042)
            $display("[TB] FAIL back_to_back_r0 got=%h exp=0042", read_data1);
        else checksPassed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        read_register0 = 3'd3;
        read_register1 = 3'd7;
        #2;
        rst_n = 1'b0;
        #1;
        checksTotal++;
        if (read_data0 !== 16'h0000 || read_data1 !== 16'h0000)
            $display("[TB] FAIL async_reset_immediate got=%h/%h exp=0000/0000", read_data0, read_data1);
        else checksPassed++;
        // Reset must also override a write that is pending while it is held.
        RegWrite       = 1'b1;
        write_register = 3'd0;
        write_data     = 16'h1357;
        read_register0 = 3'd0;
        @(posedge clk);
        #1;
        checksTotal++;
        if (read_data0 !== 16'h0000)
            $display("[TB] FAIL reset_overrides_write got=%h exp=0000", read_data0);
        else checksPassed++;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) model[a] = 16'h0000;
        #1;
        checksTotal++;
        if (read_data0 !== 16'h0000)
            $display("[TB] FAIL release_before_edge got=%h exp=0000", read_data0);
        else checksPassed++;
        @(posedge clk);
        #1;
        checksTotal++;
        if (read_data0 !== 16'h1357)
            $display("[TB] FAIL first_write_after_release got=%h exp=1357", read_data0);
        else checksPassed++;
        @(negedge clk);
        RegWrite = 1'b0;
        model[0] = 16'h1357;
        for (int a = 1; a < 8; a++) begin
            read_register1 = a[2:0];
            #1;
            checksTotal++;
            if (read_data1 !== 16'h0000)
                $display("[TB] FAIL stay_zero addr=%0d got=%h exp=0000", a, read_data1);
            else checksPassed++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  wa;
            logic [15:0] wd;
            logic [2:0]  ra0;
            logic [2:0]  ra1;
            we  = 1'($urandom_range(0, 1));
            wa  = 3'($urandom_range(0, 7));
            wd  = 16'($urandom);
            ra0 = 3'($urandom_range(0, 7));
            ra1 = (n % 4 == 0) ? wa : 3'($urandom_range(0, 7));
            @(negedge clk);
            RegWrite       = we;
            write_register = wa;
            write_data     = wd;
            read_register0 = ra0;
            read_register1 = ra1;
            #1;
            checksTotal++;
            if (read_data0 !== model[ra0] || read_data1 !== model[ra1])
                $display("[TB] FAIL rand_pre n=%0d got=%h/%h exp=%h/%h", n, read_data0, read_data1, model[ra0], model[ra1]);
            else checksPassed++;
            @(posedge clk);
            if (we) model[wa] = wd;
            #1;
            checksTotal++;
            if (read_data0 !== model[ra0] || read_data1 !== model[ra1])
                $display("[TB] FAIL rand_post n=%0d got=%h/%h exp=%h/%h", n, read_data0, read_data1, model[ra0], model[ra1]);
            else checksPassed++;
        end
        @(negedge clk);
        RegWrite = 1'b0;
    endtask

    initial begin
        checksTotal    = 0;
        checksPassed   = 0;
        RegWrite       = 1'b0;
        write_register = 3'd0;
        write_data     = 16'h0000;
        read_register0 = 3'd0;
        read_register1 = 3'd0;
        rst_n          = 1'b0;
        for (int a = 0; a < 8; a++) model[a] = 16'h0000;
        #2;
        test_reset();
        test_basic_writes();
        test_write_enable();
        test_same_cycle_read();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
